// File: rtl/add_arb_pkg.sv
// Shared types and defaults for the add_arbiter slice: FSM state encoding and
// default requester count / operand width.
package add_arb_pkg;
    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/add_rr_pick.sv
// Winner selection: first valid requester found searching upward from i_ptr,
// wrapping modulo NREQ (NREQ is a power of two, so index arithmetic wraps itself).
module add_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);
    // Walk from the farthest offset back to ptr so the nearest valid one wins.
    always_comb begin
        logic [IW-1:0] w_j;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_j = i_ptr + k[IW-1:0];
            if (i_valid[w_j]) begin
                o_grant      = '0;
                o_grant[w_j] = 1'b1;
                o_idx        = w_j;
                o_any        = 1'b1;
            end
        end
    end
endmodule

// File: rtl/add_arbiter.sv
// NREQ-way arbiter feeding a single a+b adder with a valid/ready result port.
// Define ADD_ARB_FIXED_PRIO_EN for lowest-index-wins; default is round-robin.
module add_arbiter
    import add_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IW-1:0]     rsp_id,
    output logic [W:0]        rsp_y,
    output logic [7:0]        done_cnt
);
    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [IW-1:0]   r_rsp_id;
    logic [W:0]      r_rsp_y;
    logic            r_rsp_valid;
    logic [7:0]      r_done_cnt;
    logic [IW-1:0]   w_ptr;
    logic [NREQ-1:0] w_grant;
    logic [IW-1:0]   w_idx;
    logic            w_any;
    logic            w_accept;
    logic [W-1:0]    w_a_sel;
    logic [W-1:0]    w_b_sel;

`ifdef ADD_ARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [IW-1:0] r_ptr;
    assign w_ptr = r_ptr;
`endif

    add_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .i_valid (req_valid),
        .i_ptr   (w_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Ready is combinational in IDLE; reset masks it so no grant escapes a reset cycle.
    assign w_accept  = (r_state == IDLE) && w_any && !rst;
    assign req_ready = w_accept ? w_grant : '0;
    assign w_a_sel   = req_a[w_idx*W +: W];
    assign w_b_sel   = req_b[w_idx*W +: W];

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_y     = r_rsp_y;
    assign done_cnt  = r_done_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_rsp_id    <= '0;
            r_rsp_y     <= '0;
            r_rsp_valid <= 1'b0;
            r_done_cnt  <= '0;
`ifndef ADD_ARB_FIXED_PRIO_EN
            r_ptr       <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a      <= w_a_sel;
                        r_b      <= w_b_sel;
                        r_rsp_id <= w_idx;
`ifndef ADD_ARB_FIXED_PRIO_EN
                        r_ptr    <= w_idx + IW'(1);
`endif
                        r_state  <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_y     <= {1'b0, r_a} + {1'b0, r_b};
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_done_cnt  <= r_done_cnt + 8'd1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_add_arbiter.sv
// Scoreboard bench for add_arbiter: a transaction-level model predicts grants,
// sums and counts; a monitor compares every cycle and at each presented result.
module tb_add_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IW   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [W:0]        rsp_y;
    logic [7:0]        done_cnt;

    add_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int y;
    } rsp_t;

    rsp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Model: 0 = free, 1 = computing, 2 = result outstanding
    int m_stage = 0;
    int m_ptr   = 0;
    int m_done  = 0;
    int m_total = 0;

    logic [NREQ-1:0] exp_ready = '0;
    logic            exp_rv    = 1'b0;
    int              exp_done  = 0;
    bit              chk_en    = 1'b0;

    logic            d_rst;
    logic [NREQ-1:0] d_valid;
    logic            d_rr;
    int              d_a [NREQ];
    int              d_b [NREQ];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // One clock cycle: drive inputs, predict this cycle's outputs, then advance the model.
    task automatic step();
        int win;
        @(negedge clk);
        rst       = d_rst;
        req_valid = d_valid;
        rsp_ready = d_rr;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = W'(d_a[i]);
            req_b[i*W +: W] = W'(d_b[i]);
        end
        exp_done  = m_done;
        exp_rv    = (m_stage == 2);
        exp_ready = '0;
        win       = -1;
        if (!d_rst && m_stage == 0 && d_valid != '0) begin
            for (int k = NREQ - 1; k >= 0; k--)
                if (d_valid[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
            exp_ready[win] = 1'b1;
        end
        chk_en = 1'b1;
        #2;
        if (d_rst) begin
            m_stage = 0; m_ptr = 0; m_done = 0; m_total = 0;
            q.delete();
        end else begin
            case (m_stage)
                0: if (win >= 0) begin
                    q.push_back('{win, d_a[win] + d_b[win]});
`ifdef ADD_ARB_FIXED_PRIO_EN
                    m_ptr = 0;
`else
                    m_ptr = (win + 1) % NREQ;
`endif
                    m_stage = 1;
                end
                1: m_stage = 2;
                default: if (d_rr) begin
                    m_stage = 0;
                    m_done  = (m_done + 1) % 256;
                    m_total++;
                end
            endcase
        end
    endtask

    task automatic drain();
        d_valid = '0;
        d_rr    = 1'b1;
        for (int c = 0; c < 8 && m_stage != 0; c++) step();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (chk_en) begin
                chk("req_ready", 32'(req_ready), 32'(exp_ready));
                chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
                chk("done_cnt", 32'(done_cnt), 32'(exp_done));
                if (rsp_valid === 1'b1) begin
                    if (q.size() == 0) begin
                        n_chk++;
                        $display("FAIL rsp_unexpected: got id %0d y %0d with no pending request", rsp_id, rsp_y);
                    end else begin
                        chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
                        chk("rsp_y", 32'(rsp_y), 32'(q[0].y));
                        if (rsp_ready && !rst) void'(q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b1; req_a = '0; req_b = '0;
        d_rst = 1'b1; d_valid = '0; d_rr = 1'b1;
        for (int i = 0; i < NREQ; i++) begin d_a[i] = 0; d_b[i] = 0; end
        repeat (2) step();

        // Reset while in EXEC: aborted, then regrant from requester 0
        d_rst = 1'b0; d_valid = 4'b0001; d_a[0] = 1; d_b[0] = 2;
        step();
        d_valid = 4'b1111; d_rst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin d_a[i] = i + 1; d_b[i] = 2 * i; end
        step();
        d_rst = 1'b0;
        repeat (6) step();
        drain();

        // Single request 3+4 on requester 0
        d_valid = 4'b0001; d_a[0] = 3; d_b[0] = 4;
        step();
        d_valid = '0;
        repeat (4) step();

        // Overflow 15+15 on requester 2
        d_valid = 4'b0100; d_a[2] = 15; d_b[2] = 15;
        step();
        d_valid = '0;
        repeat (4) step();

        // All requesters continuously valid, distinct sums per lane
        for (int i = 0; i < NREQ; i++) begin d_a[i] = i; d_b[i] = 3 * i + 1; end
        d_valid = 4'b1111;
        repeat (15) step();
        drain();

        // Backpressure: result held for several cycles with requests pending
        d_valid = 4'b0100; d_a[2] = 9; d_b[2] = 5;
        step();
        d_valid = 4'b1111; d_rr = 1'b0;
        repeat (7) step();
        d_rr = 1'b1;
        step();
        drain();

        // Random traffic
        repeat (400) begin
            d_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                d_a[i] = int'($urandom_range(0, 15));
                d_b[i] = int'($urandom_range(0, 15));
            end
            d_rr = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        // Counter wrap: more than 256 completions after a reset
        d_rst = 1'b1; step();
        d_rst = 1'b0; d_valid = 4'b1111; d_rr = 1'b1;
        for (int c = 0; c < 900 && m_total < 258; c++) step();
        drain();
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter NREQ SHALL default to 4 and set the number of requesters (power of two, 2..8).
REQ-003 Parameter W SHALL default to 4 and set the operand width.
REQ-004 clk  in  1  SHALL be the only clock.
REQ-005 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-006 req_valid  in  NREQ  SHALL carry one request-valid bit per requester.
REQ-007 req_ready  out  NREQ  SHALL carry one accept bit per requester, at most one high.
REQ-008 req_a  in  NREQ*W  SHALL carry operand a; slice i belongs to requester i.
REQ-009 req_b  in  NREQ*W  SHALL carry operand b; slice i belongs to requester i.
REQ-010 rsp_valid  out  1  SHALL flag that a result is presented.
REQ-011 rsp_ready  in  1  SHALL be the consumer's accept for the result.
REQ-012 rsp_id  out  log2(NREQ)  SHALL give the index of the requester that owns the result.
REQ-013 rsp_y  out  W+1  SHALL carry the sum a+b.
REQ-014 done_cnt  out  8  SHALL count completed transactions.

Function
REQ-015 FSM states SHALL be IDLE, EXEC and RESP; the reset state is IDLE.
REQ-016 In IDLE with any req_valid high, req_ready[winner] SHALL be driven combinationally in the same cycle; operands and id latch and the FSM goes to EXEC.
REQ-017 req_ready SHALL be all-zero in EXEC and RESP, and in IDLE when no request is valid.
REQ-018 In EXEC, rsp_y SHALL register a+b zero-extended to W+1 bits (no truncation: 15+15=30) and the FSM goes to RESP.
REQ-019 In RESP, rsp_valid SHALL be 1; rsp_y and rsp_id SHALL hold stable until rsp_ready.
REQ-020 On rsp_valid & rsp_ready, the FSM SHALL return to IDLE and done_cnt SHALL increment, wrapping 255->0.
REQ-021 Minimum accept-to-accept spacing SHALL be 3 cycles; result latency SHALL be 2 cycles from accept to rsp_valid.
REQ-022 Winner (default): round-robin; search starts at ptr; after a grant ptr = winner+1 mod NREQ.
REQ-023 A requester that deasserts req_valid before being granted SHALL be dropped silently; a request is never granted twice.
REQ-024 Requests arriving in EXEC or RESP SHALL wait (no loss while req_valid is held).

Reset
REQ-025 Reset SHALL set state=IDLE, ptr=0, rsp_valid=0, rsp_y=0, rsp_id=0, done_cnt=0 and req_ready=0 on the next clk edge.
REQ-026 Reset mid-transaction SHALL abort it with no response emitted and no done_cnt increment; reset SHALL win over any simultaneous handshake.

Configuration
REQ-027 Macro ADD_ARB_FIXED_PRIO_EN SHALL select arbitration mode.
REQ-028 With ADD_ARB_FIXED_PRIO_EN defined, the lowest valid index SHALL always win and ptr logic is removed.
REQ-029 Without ADD_ARB_FIXED_PRIO_EN, round-robin per REQ-022 SHALL apply.

Structure
REQ-030 Package add_arb_pkg SHALL hold the state enum (IDLE/EXEC/RESP) and the defaults NREQ_DEF=4, W_DEF=4.
REQ-031 Winner selection SHALL live in sub-module add_rr_pick (inputs: valid vector, ptr; outputs: one-hot grant, index, any).

Verification
REQ-032 Single request: req_valid=0001, a=3, b=4 -> req_ready=0001 same cycle; rsp_valid 2 cycles later; rsp_y=7, rsp_id=0; done_cnt=1.
REQ-033 Overflow: a=15, b=15 -> rsp_y=30 (5'b11110).
REQ-034 Round-robin with all four requesters valid continuously -> grant order 0,1,2,3,0; with the macro defined, order 0,0,0.
REQ-035 Backpressure: rsp_ready low for 5 cycles -> rsp_valid/rsp_y/rsp_id stable, req_ready=0 throughout, then a single completion.
REQ-036 Reset asserted in EXEC -> next cycle rsp_valid=0, state IDLE, done_cnt unchanged; pending requests are regranted from ptr=0.
REQ-037 256 completions -> done_cnt wraps to 0.
